dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
- The CPU asserts a request with address, write enable and write data. This block accepts it, waits a programmable latency, commits the access to its word array, then returns an ack pulse with read data and an error flag.
- It drives a stall back to the CPU's hazard logic while a request is outstanding.
- It replaces the zero-latency data memory model once the pipeline registers and forwarding unit are in place.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Optional byte-lane writes are enabled by defining DMEM_RESP_BYTE_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef DMEM_RESP_BYTE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [3:0]         be_in_s;
    logic               enter_resp_s;
    logic               acc_err_s;
    logic               wr_en_s;
    logic [ADDR_W-1:0]  widx_s;
    logic [31:0]        rd_word_s;

    function automatic logic addr_error(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

`ifdef DMEM_RESP_BYTE_EN
    assign be_in_s = be_i;
`else
    assign be_in_s = 4'hF;
`endif

    // Commit happens on the edge that enters RESP, using the captured request.
    assign enter_resp_s = (state_q == BUSY) && (cnt_q == 4'd0);
    assign acc_err_s    = addr_error(addr_q);
    assign wr_en_s      = enter_resp_s && we_q && !acc_err_s;
    assign widx_s       = addr_q[ADDR_W+1:2];
    assign rd_word_s    = mem_q[widx_s];

    // Next-state, request capture and response register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE, RESP: begin
                // The counter holds the BUSY edges still to go before RESP.
                if (req_i) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_in_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        ack_d   = enter_resp_s;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (enter_resp_s) begin
            err_d = acc_err_s;
            if (acc_err_s) begin
                rdata_d = 32'h0000_0000;
            end else if (!we_q) begin
                rdata_d = rd_word_s;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            err_d = err_q;
        end
    end

    // Control and response registers; a reset drops any pending access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Word array write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int n = 0; n < 4; n++) begin
                if (be_q[n]) begin
                    mem_q[widx_s][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

    assign ready_o = (state_q != BUSY);
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: instance 0 uses LATENCY=3, instance 1 LATENCY=1.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ready [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        stall [2];

    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] mdl [int];
    logic [31:0] last_rd [2];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]),
`ifdef DMEM_RESP_BYTE_EN
        .be_i(be[0]),
`endif
        .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .stall_o(stall[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]),
`ifdef DMEM_RESP_BYTE_EN
        .be_i(be[1]),
`endif
        .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .stall_o(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Present a request now (at a negedge), follow it to its ack and check it against the model.
    // Returns in the ack cycle with req still high, so the caller may chain or go idle.
    task automatic issue(input int sel, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        int          cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] old;
        logic [3:0]  eff_be;
        int          key;
        bit          known;
        exp_err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        key     = sel * 65536 + int'(a[9:2]);
`ifdef DMEM_RESP_BYTE_EN
        eff_be = b;
`else
        eff_be = 4'hF;
`endif
        chk("ready_at_req", 32'(ready[sel]), 32'd1);
        req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d; be[sel] = b;
        @(posedge clk);
        @(negedge clk);
        chk("ready_in_busy", 32'(ready[sel]), 32'd0);
        cyc = 0;
        while (ack[sel] !== 1'b1 && cyc < 40) begin
            chk("stall_while_pending", 32'(stall[sel]), 32'd1);
            we[sel] = 1'($urandom); addr[sel] = $urandom; wdata[sel] = $urandom; be[sel] = 4'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("ack_latency", 32'(cyc), 32'(lat_of(sel)));
        known = 1'b1;
        if (exp_err) begin
            exp_rd = 32'h0;
        end else if (w) begin
            old = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int n = 0; n < 4; n++) begin
                if (eff_be[n]) old[8*n +: 8] = d[8*n +: 8];
            end
            mdl[key] = old;
            exp_rd = last_rd[sel];
        end else begin
            known  = mdl.exists(key);
            exp_rd = known ? mdl[key] : 32'h0;
        end
        chk("err", 32'(err[sel]), 32'(exp_err));
        if (known) chk("rdata", rdata[sel], exp_rd);
        last_rd[sel] = rdata[sel];
        if (known) last_rd[sel] = exp_rd;
        chk("stall_at_ack", 32'(stall[sel]), 32'd0);
    endtask

    task automatic go_idle(input int sel);
        req[sel] = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(ack[sel]), 32'd0);
        chk("rdata_held", rdata[sel], last_rd[sel]);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = 32'h0; wdata[s] = 32'h0; be[s] = 4'hF;
            last_rd[s] = 32'h0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", 32'(ack[s]), 32'd0);
            chk("rst_err", 32'(err[s]), 32'd0);
            chk("rst_rdata", rdata[s], 32'h0);
            chk("rst_ready", 32'(ready[s]), 32'd1);
            chk("rst_stall", 32'(stall[s]), 32'd0);
        end

        // Store then load the same word.
        issue(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF); go_idle(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("t1_load", rdata[0], 32'h1234_5678);
        go_idle(0);

        // Back-to-back: load presented in the store's ack cycle.
        issue(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
        chk("t2_load", rdata[0], 32'hCAFE_F00D);
        go_idle(0);

        // Error accesses leave the array alone.
        issue(0, 1'b0, 32'h13, 32'h0, 4'hF); go_idle(0);
        issue(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF); go_idle(0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        chk("t3_after_err", rdata[0], 32'h1234_5678);
        go_idle(0);

        // Reset in the middle of a store drops it.
        issue(0, 1'b1, 32'h30, 32'h1111_1111, 4'hF); go_idle(0);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(ack[0]), 32'd0);
        chk("rst_mid_ready", 32'(ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", 32'(ack[0]), 32'd0);
        end
        issue(0, 1'b0, 32'h30, 32'h0, 4'hF);
        chk("t4_old_contents", rdata[0], 32'h1111_1111);
        go_idle(0);

        // Randomised traffic on the LATENCY=3 instance.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic        w;
            int          r;
            a = 32'h100 + 32'(4 * $urandom_range(7, 0));
            r = $urandom_range(9, 0);
            w = 1'($urandom);
            if (!mdl.exists(int'(a[9:2]))) w = 1'b1;
            if (r == 0) a = a + 32'($urandom_range(3, 1));
            if (r == 1) a = 32'h400 + 32'(4 * $urandom_range(63, 0));
            issue(0, w, a, $urandom, 4'hF);
            if ($urandom_range(1, 0) == 0) go_idle(0);
        end
        go_idle(0);

        // LATENCY=1: alternating stores and loads with req held high.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(((i / 2) % 2) * 4);
            issue(1, (i % 2) == 0, a, $urandom, 4'hF);
        end
        go_idle(1);

`ifdef DMEM_RESP_BYTE_EN
        issue(0, 1'b1, 32'h50, 32'h1234_5678, 4'hF); go_idle(0);
        issue(0, 1'b1, 32'h50, 32'hAABB_CCDD, 4'b0011); go_idle(0);
        issue(0, 1'b0, 32'h50, 32'h0, 4'hF);
        chk("t6_lanes", rdata[0], 32'h1234_CCDD);
        go_idle(0);
        issue(0, 1'b1, 32'h50, 32'h5555_5555, 4'b0000);
        chk("t6_be0_err", 32'(err[0]), 32'd0);
        go_idle(0);
        issue(0, 1'b0, 32'h50, 32'h0, 4'hF);
        chk("t6_be0_load", rdata[0], 32'h1234_CCDD);
        go_idle(0);
`endif

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
